// File: rtl/sort_pkg.sv
// Shared definitions for the 16x8-bit sorter datapath: the feeder, the sorter
// and the output-side drain stage all agree on frame size and pad byte here.
package sort_pkg;

  localparam int SORT_NB = 16;
  localparam logic [7:0] SORT_PAD_BYTE = 8'hFF;

  typedef logic [8*SORT_NB-1:0] frame_t;

  // Number of set flags in a two-bank full vector.
  function automatic logic [1:0] count_full(input logic [1:0] full);
    return {1'b0, full[0]} + {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// One frame bank of the sort feeder: NB byte lanes, single-byte write by
// index, plus pad fill of the lanes from the write index onward. When a byte
// is written in the same cycle as a pad, the byte keeps its lane and padding
// starts at the following lane.
module feeder_bank
  import sort_pkg::*;
#(
  parameter int NB = SORT_NB,
  localparam int IW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [7:0]      wr_data,
  input  logic            pad_en,
  output logic [8*NB-1:0] data
);

  // Lane storage: indexed byte write has priority over pad fill on its lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_en && (wr_idx == IW'(i))) begin
          data[8*i +: 8] <= wr_data;
        end else if (pad_en && (IW'(i) >= wr_idx)) begin
          data[8*i +: 8] <= SORT_PAD_BYTE;
        end
      end
    end
  end

endmodule

// File: rtl/sort_feeder.sv
// Upstream stage of the 16x8-bit sorter. Packs a valid/ready byte stream into
// NB-byte frames held in two ping-pong banks and launches each full frame into
// the sorter with a one-cycle en strobe whenever the sorter is not busy.
// Optional feature: define SORT_FEEDER_FLUSH_EN to add flush_i, which closes a
// partially filled frame by padding its remaining lanes with SORT_PAD_BYTE.
module sort_feeder
  import sort_pkg::*;
#(
  parameter int NB = SORT_NB,
  parameter int CW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  input  logic [7:0]      in_data_i,
  output logic            in_ready_o,
  input  logic            sort_busy_i,
  output logic            sort_en_o,
  output logic [8*NB-1:0] sort_data_o,
  output logic [1:0]      pending_o,
  output logic [CW-1:0]   frame_cnt_o
`ifdef SORT_FEEDER_FLUSH_EN
  ,
  input  logic            flush_i
`endif
);

  localparam int IW = $clog2(NB);

  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   frame_cnt;
  logic [1:0]      pending;
  logic            accept;
  logic            complete;
  logic            flush_do;
  logic            close;
  logic            launch;
  logic [8*NB-1:0] bank_data [2];

  assign in_ready_o  = ~full[wr_bank];
  assign accept      = in_valid_i & in_ready_o;
  assign complete    = accept & (idx == IW'(NB-1));
  // A flush that coincides with the completing byte is redundant: the frame
  // is already closing on its own.
`ifdef SORT_FEEDER_FLUSH_EN
  assign flush_do    = flush_i & ~full[wr_bank] & (idx != '0) & ~complete;
`else
  assign flush_do    = 1'b0;
`endif
  assign close       = complete | flush_do;
  assign launch      = full[rd_bank] & ~sort_busy_i;

  assign sort_en_o   = launch;
  assign sort_data_o = rd_bank ? bank_data[1] : bank_data[0];
  assign pending_o   = pending;
  assign frame_cnt_o = frame_cnt;

  feeder_bank #(.NB(NB)) u_bank0 (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .wr_en   (accept & ~wr_bank),
    .wr_idx  (idx),
    .wr_data (in_data_i),
    .pad_en  (flush_do & ~wr_bank),
    .data    (bank_data[0])
  );

  feeder_bank #(.NB(NB)) u_bank1 (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .wr_en   (accept & wr_bank),
    .wr_idx  (idx),
    .wr_data (in_data_i),
    .pad_en  (flush_do & wr_bank),
    .data    (bank_data[1])
  );

  // Next full flags: closing only ever targets an empty bank and launching
  // only a full one, so the two updates never touch the same bank.
  always_comb begin
    full_nxt = full;
    if (launch) full_nxt[rd_bank] = 1'b0;
    if (close)  full_nxt[wr_bank] = 1'b1;
  end

  // Bank pointers, fill index, full flags, pending count and launch counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      idx       <= '0;
      full      <= '0;
      pending   <= '0;
      frame_cnt <= '0;
    end else begin
      if (close) begin
        idx     <= '0;
        wr_bank <= ~wr_bank;
      end else if (accept) begin
        idx     <= idx + 1'b1;
      end
      if (launch) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 1'b1;
      end
      full    <= full_nxt;
      pending <= count_full(full_nxt);
    end
  end

endmodule

// File: tb/tb_sort_feeder.sv
// Self-checking bench for sort_feeder (NB=16, CW=4). Directed scenarios with
// hand-computed frames, plus a long random stream checked against the
// accepted-byte order. Flush scenarios build only with SORT_FEEDER_FLUSH_EN.
module tb_sort_feeder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         sort_busy;
  logic         sort_en;
  logic [127:0] sort_data;
  logic [1:0]   pending;
  logic [3:0]   frame_cnt;
`ifdef SORT_FEEDER_FLUSH_EN
  logic         flush;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  logic [7:0]   acc_q [$];
  logic [127:0] frm_q [$];
  int           lc_q  [$];
  bit           stream_done;

  sort_feeder #(.NB(16), .CW(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .sort_busy_i (sort_busy),
    .sort_en_o   (sort_en),
    .sort_data_o (sort_data),
    .pending_o   (pending),
    .frame_cnt_o (frame_cnt)
`ifdef SORT_FEEDER_FLUSH_EN
    ,
    .flush_i     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe accepted bytes and launched frames between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_q.push_back(in_data);
        last_acc_cyc = cyc;
      end
      if (sort_en) begin
        frm_q.push_back(sort_data);
        lc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc_q.delete();
    frm_q.delete();
    lc_q.delete();
  endtask

  // Present one byte and hold it until accepted; returns just after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %0h: in_ready stayed %0b, required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    sort_busy = 1'b0;
`ifdef SORT_FEEDER_FLUSH_EN
    flush     = 1'b0;
`endif
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);
    clear_obs();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    checks++; if (sort_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", sort_en); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
    checks++; if (sort_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", sort_data); end
    checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
    wait_cycles(1);
  endtask

  task automatic test_single_frame();
    clear_obs();
    sort_busy = 1'b0;
    for (int k = 0; k < 16; k++) send_byte(8'(8'h10 + k));
    wait_cycles(3);
    checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL t1_launches got %0d want 1", frm_q.size()); end
    if (frm_q.size() >= 1) begin
      checks++; if (frm_q[0] !== 128'h1F1E1D1C_1B1A1918_17161514_13121110) begin errors++; $display("FAIL t1_frame got %h want 1f1e..1110", frm_q[0]); end
      checks++; if (lc_q[0] !== last_acc_cyc + 1) begin errors++; $display("FAIL t1_latency got %0d want 1", lc_q[0] - last_acc_cyc); end
    end
    checks++; if (frame_cnt !== 4'd1) begin errors++; $display("FAIL t1_cnt got %0d want 1", frame_cnt); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL t1_pending got %0d want 0", pending); end
  endtask

  task automatic test_backpressure();
    int n;
    clear_obs();
    sort_busy = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) send_byte(8'(8'h40 + k));
      end
      begin
        n = 0;
        @(negedge clk);
        while (in_ready && n < 500) begin
          n++;
          @(negedge clk);
        end
        checks++; if (acc_q.size() !== 32) begin errors++; $display("FAIL t2_stall_at got %0d want 32", acc_q.size()); end
        checks++; if (pending !== 2'd2) begin errors++; $display("FAIL t2_pending_full got %0d want 2", pending); end
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t2_stall_hold got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
        sort_busy = 1'b0;
        @(negedge clk);
        checks++; if ({sort_en, in_ready} !== 2'b10) begin errors++; $display("FAIL t2_launch_cycle en,ready got %b want 10", {sort_en, in_ready}); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after got %0b want 1", in_ready); end
      end
    join
    for (int k = 40; k < 48; k++) send_byte(8'(8'h40 + k));
    wait_cycles(3);
    checks++; if (frm_q.size() !== 3) begin errors++; $display("FAIL t2_launches got %0d want 3", frm_q.size()); end
    if (frm_q.size() >= 3) begin
      checks++; if (frm_q[0] !== 128'h4F4E4D4C_4B4A4948_47464544_43424140) begin errors++; $display("FAIL t2_frame0 got %h want 4f4e..4140", frm_q[0]); end
      checks++; if (frm_q[1] !== 128'h5F5E5D5C_5B5A5958_57565554_53525150) begin errors++; $display("FAIL t2_frame1 got %h want 5f5e..5150", frm_q[1]); end
      checks++; if (frm_q[2] !== 128'h6F6E6D6C_6B6A6968_67666564_63626160) begin errors++; $display("FAIL t2_frame2 got %h want 6f6e..6160", frm_q[2]); end
    end
    checks++; if (frame_cnt !== 4'd4) begin errors++; $display("FAIL t2_cnt got %0d want 4", frame_cnt); end
  endtask

  task automatic test_same_cycle();
    clear_obs();
    sort_busy = 1'b1;
    for (int k = 0; k < 31; k++) send_byte(8'(8'h80 + k));
    checks++; if (pending !== 2'd1) begin errors++; $display("FAIL t3_pending_pre got %0d want 1", pending); end
    sort_busy = 1'b0;
    send_byte(8'h9F);
    sort_busy = 1'b1;
    @(negedge clk);
    checks++; if (pending !== 2'd1) begin errors++; $display("FAIL t3_pending_same got %0d want 1", pending); end
    checks++; if (sort_en !== 1'b0) begin errors++; $display("FAIL t3_en_busy got %0b want 0", sort_en); end
    checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL t3_first_launch got %0d want 1", frm_q.size()); end
    else begin
      checks++; if (lc_q[0] !== last_acc_cyc) begin errors++; $display("FAIL t3_coincide launch cyc %0d want %0d", lc_q[0], last_acc_cyc); end
    end
    wait_cycles(3);
    sort_busy = 1'b0;
    wait_cycles(2);
    checks++; if (frm_q.size() !== 2) begin errors++; $display("FAIL t3_launches got %0d want 2", frm_q.size()); end
    if (frm_q.size() >= 2) begin
      checks++; if (frm_q[0] !== 128'h8F8E8D8C_8B8A8988_87868584_83828180) begin errors++; $display("FAIL t3_frame0 got %h want 8f8e..8180", frm_q[0]); end
      checks++; if (frm_q[1] !== 128'h9F9E9D9C_9B9A9998_97969594_93929190) begin errors++; $display("FAIL t3_frame1 got %h want 9f9e..9190", frm_q[1]); end
    end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL t3_pending_end got %0d want 0", pending); end
  endtask

  task automatic test_reset_mid_frame();
    sort_busy = 1'b1;
    for (int k = 0; k < 7; k++) send_byte(8'(8'hC0 + k));
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sort_data !== 128'h0) begin errors++; $display("FAIL t4_async_data got %h want 0", sort_data); end
    checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL t4_async_cnt got %0d want 0", frame_cnt); end
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    clear_obs();
    sort_busy = 1'b0;
    for (int k = 0; k < 16; k++) send_byte(8'(8'hA0 + k));
    wait_cycles(3);
    checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL t4_launches got %0d want 1", frm_q.size()); end
    if (frm_q.size() >= 1) begin
      checks++; if (frm_q[0] !== 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0) begin errors++; $display("FAIL t4_frame got %h want afae..a1a0", frm_q[0]); end
    end
    checks++; if (frame_cnt !== 4'd1) begin errors++; $display("FAIL t4_cnt got %0d want 1", frame_cnt); end
  endtask

`ifdef SORT_FEEDER_FLUSH_EN
  task automatic test_flush();
    clear_obs();
    sort_busy = 1'b1;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h09);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    @(negedge clk);
    checks++; if (pending !== 2'd1) begin errors++; $display("FAIL t5_pending got %0d want 1", pending); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t5_ready got %0b want 1", in_ready); end
    sort_busy = 1'b0;
    wait_cycles(2);
    checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL t5_launches got %0d want 1", frm_q.size()); end
    if (frm_q.size() >= 1) begin
      checks++; if (frm_q[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FF090305) begin errors++; $display("FAIL t5_frame got %h want ff..ff090305", frm_q[0]); end
    end
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_cycles(3);
    checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL t5_idle_flush launches got %0d want 1", frm_q.size()); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL t5_idle_flush pending got %0d want 0", pending); end
    send_byte(8'h11);
    send_byte(8'h22);
    flush = 1'b1;
    send_byte(8'h77);
    flush = 1'b0;
    wait_cycles(2);
    checks++; if (frm_q.size() !== 2) begin errors++; $display("FAIL t5_byte_flush launches got %0d want 2", frm_q.size()); end
    if (frm_q.size() >= 2) begin
      checks++; if (frm_q[1] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FF772211) begin errors++; $display("FAIL t5_byte_flush frame got %h want ff..ff772211", frm_q[1]); end
    end
  endtask
`endif

  task automatic test_random_stream();
    int n;
    int nf;
    logic [127:0] exp_f;
    apply_reset();
    stream_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 16000; k++) begin
          if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 4));
          send_byte(8'($urandom()));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          if (sort_en) begin
            @(posedge clk);
            #1;
            sort_busy = 1'b1;
            wait_cycles($urandom_range(1, 8));
            sort_busy = 1'b0;
          end
        end
      end
    join
    sort_busy = 1'b0;
    n = 0;
    while (frm_q.size() < 1000 && n < 200) begin
      n++;
      wait_cycles(1);
    end
    wait_cycles(2);
    checks++; if (frm_q.size() !== 1000) begin errors++; $display("FAIL t6_launches got %0d want 1000", frm_q.size()); end
    checks++; if (acc_q.size() !== 16000) begin errors++; $display("FAIL t6_accepts got %0d want 16000", acc_q.size()); end
    nf = (frm_q.size() < acc_q.size() / 16) ? frm_q.size() : acc_q.size() / 16;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < 16; i++) exp_f[8*i +: 8] = acc_q[16*f + i];
      checks++;
      if (frm_q[f] !== exp_f) begin errors++; $display("FAIL t6_frame%0d got %h want %h", f, frm_q[f], exp_f); end
    end
    checks++; if (frame_cnt !== 4'd8) begin errors++; $display("FAIL t6_cnt_wrap got %0d want 8", frame_cnt); end
    checks++; if (pending !== 2'd0) begin errors++; $display("FAIL t6_pending got %0d want 0", pending); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    sort_busy = 1'b0;
`ifdef SORT_FEEDER_FLUSH_EN
    flush     = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_backpressure();
    test_same_cycle();
    test_reset_mid_frame();
`ifdef SORT_FEEDER_FLUSH_EN
    test_flush();
`endif
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
